// File: rtl/adc_cap_pkg.sv
// Shared types and constants for the ADC frame capture block.
// Holds the capture FSM encoding and the stored sample format.
package adc_cap_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRE       = 3'd1,
        WAIT_TRIG = 3'd2,
        POST      = 3'd3,
        DONE      = 3'd4
    } cap_state_e;

    localparam logic [13:0] ADC_MID = 14'h2000;

    typedef struct packed {
        logic        of;
        logic [13:0] data;
    } cap_smp_t;

endpackage

// File: rtl/adc_frame_capture_cap_dpram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// The array has no reset so it maps onto block RAM; only the read register resets.
module cap_dpram
    import adc_cap_pkg::*;
#(
    parameter int AW = 10,
    parameter int W  = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [2**AW];
    logic [W-1:0] rdata_q;

    // Sample write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered read port, cleared on reset so rd_data starts at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/adc_frame_capture.sv
// ADC frame capture: circular pre-trigger buffer, immediate/level trigger, FMC readout.
// Build option ADC_OVR_CNT_EN enables the per-frame over-range sample counter.
module adc_frame_capture
    import adc_cap_pkg::*;
#(
    parameter int DATA_W = 14,
    parameter int AW     = 10
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              smp_vld,
    input  logic [DATA_W-1:0] ad_data,
    input  logic              ad_of,
    input  logic              arm,
    input  logic              abort,
    input  logic              trig_mode,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [AW-1:0]     pre_len,
    input  logic [AW-1:0]     rd_addr,
    output logic [15:0]       rd_data,
    output logic              busy,
    output logic              frame_ready,
    output logic              frame_int,
    output logic [15:0]       ovr_cnt
);

    localparam int            DEPTH = 2**AW;
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

    cap_state_e        state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     start_ptr_q, start_ptr_d;
    logic [AW-1:0]     pre_cnt_q, pre_cnt_d;
    logic [AW-1:0]     post_rem_q, post_rem_d;
    logic [AW-1:0]     pre_len_q, pre_len_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] level_q, level_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              prev_vld_q, prev_vld_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              int_q, int_d;

    logic              capturing;
    logic              wr_en;
    logic              arm_ok;
    logic              lvl_hit;
    logic              trig_hit;
    logic [DATA_W:0]   ram_rdata;

    // A write happens on every strobe while capturing, unless aborted
    assign capturing = (state_q == PRE) || (state_q == WAIT_TRIG) ||
                       (state_q == POST);
    assign wr_en     = capturing && smp_vld && !abort;
    assign arm_ok    = arm && !abort && !busy_q &&
                       ((state_q == IDLE) || (state_q == DONE));
    assign lvl_hit   = prev_vld_q && (prev_q < level_q) &&
                       (ad_data >= level_q);
    assign trig_hit  = wr_en && (state_q == WAIT_TRIG) &&
                       (!mode_q || lvl_hit);

    // Capture FSM, pointer and flag next-state logic
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        start_ptr_d = start_ptr_q;
        pre_cnt_d   = pre_cnt_q;
        post_rem_d  = post_rem_q;
        pre_len_d   = pre_len_q;
        mode_d      = mode_q;
        level_d     = level_q;
        prev_d      = prev_q;
        prev_vld_d  = prev_vld_q;
        busy_d      = busy_q;
        ready_d     = ready_q;
        int_d       = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (arm_ok) begin
                    pre_len_d  = pre_len;
                    mode_d     = trig_mode;
                    level_d    = trig_level;
                    pre_cnt_d  = '0;
                    prev_vld_d = 1'b0;
                    ready_d    = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = (pre_len == '0) ? WAIT_TRIG : PRE;
                end
            end
            PRE: begin
                if (wr_en) begin
                    pre_cnt_d = pre_cnt_q + 1'b1;
                    if (pre_cnt_d == pre_len_q) begin
                        state_d = WAIT_TRIG;
                    end
                end
            end
            WAIT_TRIG: begin
                if (trig_hit) begin
                    start_ptr_d = wr_ptr_q - pre_len_q;
                    post_rem_d  = LAST - pre_len_q;
                    if (pre_len_q == LAST) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                        int_d   = 1'b1;
                    end else begin
                        state_d = POST;
                    end
                end
            end
            POST: begin
                if (wr_en) begin
                    post_rem_d = post_rem_q - 1'b1;
                    if (post_rem_q == AW'(1)) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                        int_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (wr_en) begin
            wr_ptr_d   = wr_ptr_q + 1'b1;
            prev_d     = ad_data;
            prev_vld_d = 1'b1;
        end

        if (abort && capturing) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            int_d   = 1'b0;
            ready_d = 1'b0;
        end
    end

    // Capture state registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            start_ptr_q <= '0;
            pre_cnt_q   <= '0;
            post_rem_q  <= '0;
            pre_len_q   <= '0;
            mode_q      <= 1'b0;
            level_q     <= '0;
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            int_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            start_ptr_q <= start_ptr_d;
            pre_cnt_q   <= pre_cnt_d;
            post_rem_q  <= post_rem_d;
            pre_len_q   <= pre_len_d;
            mode_q      <= mode_d;
            level_q     <= level_d;
            prev_q      <= prev_d;
            prev_vld_q  <= prev_vld_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            int_q       <= int_d;
        end
    end

`ifdef ADC_OVR_CNT_EN
    logic [15:0] ovr_q, ovr_d;

    // Saturating count of over-range samples written in this capture
    always_comb begin
        ovr_d = ovr_q;
        if (arm_ok) begin
            ovr_d = '0;
        end else if (wr_en && ad_of && (ovr_q != 16'hFFFF)) begin
            ovr_d = ovr_q + 16'd1;
        end
    end

    // Over-range counter register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ovr_q <= '0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign ovr_cnt = ovr_q;
`else
    assign ovr_cnt = '0;
`endif

    cap_dpram #(
        .AW (AW),
        .W  (DATA_W + 1)
    ) u_ram (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata ({ad_of, ad_data}),
        .raddr (start_ptr_q + rd_addr),
        .rdata (ram_rdata)
    );

    assign rd_data     = 16'(ram_rdata);
    assign busy        = busy_q;
    assign frame_ready = ready_q;
    assign frame_int   = int_q;

endmodule

// File: tb/tb_adc_frame_capture.sv
// Self-checking bench for adc_frame_capture (AW=4, DEPTH=16).
// Sample-history reference model plus directed and randomized captures.
module tb_adc_frame_capture;
    import adc_cap_pkg::*;

    localparam int DW    = 14;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
`ifdef ADC_OVR_CNT_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          smp_vld = 1'b0;
    logic [DW-1:0] ad_data = '0;
    logic          ad_of = 1'b0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic          trig_mode = 1'b0;
    logic [DW-1:0] trig_level = '0;
    logic [AW-1:0] pre_len = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [15:0]   rd_data;
    logic          busy;
    logic          frame_ready;
    logic          frame_int;
    logic [15:0]   ovr_cnt;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    adc_frame_capture #(.DATA_W(DW), .AW(AW)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .smp_vld     (smp_vld),
        .ad_data     (ad_data),
        .ad_of       (ad_of),
        .arm         (arm),
        .abort       (abort),
        .trig_mode   (trig_mode),
        .trig_level  (trig_level),
        .pre_len     (pre_len),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .busy        (busy),
        .frame_ready (frame_ready),
        .frame_int   (frame_int),
        .ovr_cnt     (ovr_cnt)
    );

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: history of every sample written since arm
    cap_smp_t    hist[$];
    cap_smp_t    frame[DEPTH];
    cap_smp_t    s;
    int          trig_idx = -1;
    int          c_pre = 0;
    bit          c_mode = 1'b0;
    int          c_lvl = 0;
    int          mn;
    bit          m_busy = 1'b0;
    bit          m_ready = 1'b0;
    bit          m_int = 1'b0;
    int          m_ovr = 0;
    bit          rd_known = 1'b0;
    logic [15:0] rd_exp = '0;

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            m_busy   = 1'b0;
            m_ready  = 1'b0;
            m_int    = 1'b0;
            m_ovr    = 0;
            rd_known = 1'b1;
            rd_exp   = '0;
        end else begin
            rd_known = m_ready;
            rd_exp   = {1'b0, frame[rd_addr]};
            m_int    = 1'b0;
            if (m_busy) begin
                if (abort) begin
                    m_busy = 1'b0;
                end else if (smp_vld) begin
                    s.of   = ad_of;
                    s.data = ad_data;
                    hist.push_back(s);
                    mn = hist.size();
                    if (ad_of && m_ovr < 65535) m_ovr++;
                    if (trig_idx < 0 && mn - 1 >= c_pre) begin
                        if (!c_mode) begin
                            trig_idx = mn - 1;
                        end else if (mn >= 2 && int'(hist[mn-2].data) < c_lvl &&
                                     int'(ad_data) >= c_lvl) begin
                            trig_idx = mn - 1;
                        end
                    end
                    if (trig_idx >= 0 && mn == trig_idx + DEPTH - c_pre) begin
                        for (int k = 0; k < DEPTH; k++)
                            frame[k] = hist[trig_idx - c_pre + k];
                        m_busy  = 1'b0;
                        m_ready = 1'b1;
                        m_int   = 1'b1;
                    end
                end
            end else if (arm && !abort) begin
                c_pre    = int'(pre_len);
                c_mode   = trig_mode;
                c_lvl    = int'(trig_level);
                hist.delete();
                trig_idx = -1;
                m_ready  = 1'b0;
                m_ovr    = 0;
                m_busy   = 1'b1;
            end
        end
    end

    // Per-cycle compare of all outputs against the model
    always @(negedge sys_clk) begin
        chk("busy", busy, m_busy);
        chk("frame_ready", frame_ready, m_ready);
        chk("frame_int", frame_int, m_int);
        chk("ovr_cnt", ovr_cnt, OVR_EN ? m_ovr : 0);
        if (rd_known) chk("rd_data", rd_data, rd_exp);
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_arm(input bit mode, input int lvl, input int pre);
        trig_mode  = mode;
        trig_level = DW'(lvl);
        pre_len    = AW'(pre);
        arm        = 1'b1;
        tick();
        arm        = 1'b0;
    endtask

    task automatic smp(input int d, input bit of);
        ad_data = DW'(d);
        ad_of   = of;
        smp_vld = 1'b1;
        tick();
        smp_vld = 1'b0;
        ad_of   = 1'b0;
    endtask

    task automatic rd(input int a, output logic [15:0] v);
        rd_addr = AW'(a);
        tick();
        @(negedge sys_clk);
        #1;
        v = rd_data;
    endtask

    task automatic sweep();
        logic [15:0] v;
        for (int k = 0; k < DEPTH; k++) rd(k, v);
    endtask

    function automatic int sine13(input int i);
        real r;
        r = 8191.0 * $sin(2.0 * 3.14159265358979 * real'(i % 13) / 13.0);
        return 8192 + $rtoi(r);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] v;
        logic [15:0] ofm;
        int          n;

        // Reset state
        @(negedge sys_clk);
        @(negedge sys_clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ready", frame_ready, 0);
        chk("rst_int", frame_int, 0);
        chk("rst_rd", rd_data, 0);
        chk("rst_ovr", ovr_cnt, 0);
        tick();
        sys_rst = 1'b0;
        tick();

        // 1: immediate trigger, ramp on every cycle
        do_arm(1'b0, 0, 0);
        for (int i = 0; i < 15; i++) smp(i, 1'b0);
        chk("t1_not_ready", frame_ready, 0);
        smp(15, 1'b0);
        chk("t1_int", frame_int, 1);
        for (int k = 0; k < DEPTH; k++) begin
            rd(k, v);
            chk("t1_rd", v, k);
        end

        // 2: level trigger on a 13-sample sine, pre_len=4
        do_arm(1'b1, 'h2000, 4);
        n = 0;
        while (busy && n < 60) begin
            smp(sine13(n), 1'b0);
            n++;
        end
        chk("t2_done", busy, 0);
        chk("t2_nsmp", n, 25);
        chk("t2_ready", frame_ready, 1);
        rd(4, v);
        chk("t2_trig_ge", v >= 16'h2000, 1);
        rd(3, v);
        chk("t2_pre_lt", v < 16'h2000, 1);

        // 3: trigger after 20 samples, frame wraps the buffer
        do_arm(1'b1, 'h2000, 4);
        for (int i = 0; i < 20; i++) smp('h100 + i, 1'b0);
        for (int j = 0; j < 12; j++) smp('h3000 + j, 1'b0);
        chk("t3_ready", frame_ready, 1);
        for (int k = 0; k < 4; k++) begin
            rd(k, v);
            chk("t3_pre", v, 'h110 + k);
        end
        for (int j = 0; j < 12; j++) begin
            rd(4 + j, v);
            chk("t3_post", v, 'h3000 + j);
        end

        // 4: abort in POST, then arm+abort together
        do_arm(1'b0, 0, 0);
        for (int i = 0; i < 4; i++) smp(i + 7, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_busy", busy, 0);
        for (int i = 0; i < 20; i++) smp(i, 1'b0);
        chk("t4_ready", frame_ready, 0);
        arm   = 1'b1;
        abort = 1'b1;
        tick();
        arm   = 1'b0;
        abort = 1'b0;
        chk("t4_arm_abort", busy, 0);

        // 5: over-range on 5 of 16 samples
        ofm = 16'h8292;
        do_arm(1'b0, 0, 0);
        for (int i = 0; i < DEPTH; i++) smp(i * 3, ofm[i]);
        chk("t5_ovr", ovr_cnt, OVR_EN ? 5 : 0);
        for (int k = 0; k < DEPTH; k++) begin
            rd(k, v);
            chk("t5_of", v[14], ofm[k]);
            chk("t5_data", v[13:0], k * 3);
        end

        // 6: reset mid-POST, then a fresh capture
        do_arm(1'b0, 0, 2);
        for (int i = 0; i < 6; i++) smp(i, 1'b1);
        sys_rst = 1'b1;
        smp_vld = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_ready", frame_ready, 0);
        chk("t6_int", frame_int, 0);
        chk("t6_rd", rd_data, 0);
        chk("t6_ovr", ovr_cnt, 0);
        tick();
        tick();
        sys_rst = 1'b0;
        tick();
        do_arm(1'b0, 0, 0);
        for (int i = 0; i < DEPTH; i++) smp($urandom, 1'b0);
        chk("t6_fresh", frame_ready, 1);
        sweep();

        // Randomized captures with stalls, stray arms and aborts
        for (int it = 0; it < 30; it++) begin
            do_arm(1'($urandom), int'($urandom_range(0, 16383)),
                   int'($urandom_range(0, DEPTH - 1)));
            for (int c = 0; c < 90 && busy; c++) begin
                smp_vld = ($urandom_range(0, 9) < 7);
                ad_data = DW'($urandom);
                ad_of   = ($urandom_range(0, 5) == 0);
                arm     = ($urandom_range(0, 29) == 0);
                tick();
            end
            smp_vld = 1'b0;
            ad_of   = 1'b0;
            arm     = 1'b0;
            if (busy) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
            end
            tick();
            if (frame_ready) sweep();
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
